accumulator_bus_arbiter: RTL and testbench
==========================================

# accumulator_bus_arbiter

Round-robin bus arbiter with ownership hold, turnaround and timeout for the shared memory bus in the parallel accumulator. Four processors raise `req` to claim the shared op/read/write bus. The arbiter grants one owner at a time and keeps the grant for as long as that owner holds `req`. After every release it inserts one dead turnaround cycle. An owner that exceeds the hold limit loses the grant and cannot win again until it drops `req`.

## Interface
- `N`, default 4: number of requesters; fixed at 4 for this design.
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per ownership; legal range 2..255.
- `clk` input, 1 bit: bus clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low; `reset==0` clears all state immediately.
- `req` input, `N` bits: request lines, one per processor; level-sensitive.
- `grant` output, `N` bits: one-hot or zero; registered.
- `busy` output, 1 bit: high while any grant is asserted; equals `|grant`.
- `owner` output, 2 bits: index of the current grantee; holds the last owner when idle.
- `timeout` output, 1 bit: one-cycle pulse on the first cycle after a forced release.

## Operation
- States:
  - IDLE: no grant.
  - OWN: one grant asserted.
  - TURN: one dead cycle, grant=0.
- Eligible set = `req & ~blocked`.
- Round-robin search:
  - Search starts at `ptr`, ascending modulo 4.
  - The first eligible index wins.
  - `ptr` resets to 0.
  - On every grant, `ptr` becomes winner+1 (mod 4).
- IDLE or TURN, eligible non-empty: go to OWN. `grant[w]=1`, `owner=w`, `hold_cnt=1`.
- IDLE, eligible empty: stay in IDLE. TURN, eligible empty: go to IDLE.
- OWN, `req[owner]==1`, `hold_cnt<MAX_HOLD`: stay in OWN; `hold_cnt` increments.
- OWN, `req[owner]==0`: go to TURN; grant clears.
- OWN, `req[owner]==1`, `hold_cnt==MAX_HOLD`: forced release.
  - Go to TURN and set `blocked[owner]`.
  - `timeout=1` for that TURN cycle only.
- `blocked[i]` clears on any edge where `req[i]==0` is sampled.
  - Clearing is independent of state.
  - A set and a clear of the same bit never coincide: the set requires `req[i]==1`.
- Requests from non-owners during OWN are ignored. No preemption.
- Grant is never asserted in two consecutive ownerships without an intervening TURN cycle.
- `hold_cnt` width is 8 bits. It never exceeds `MAX_HOLD`.
- Reset values:
  - `grant=0`, `busy=0`, `owner=0`, `timeout=0`.
  - `ptr=0`, `blocked=0`, `hold_cnt=0`, state=IDLE.
- Reset asserted mid-ownership drops the grant asynchronously. After reset deasserts, arbitration restarts from `ptr=0`.

## Timing
- Request latency: `req` sampled high in IDLE at edge k gives `grant` high after edge k (visible in cycle k+1).
- Release latency: `req[owner]` sampled low at edge m.
  - `grant` low in cycle m+1 (TURN).
  - Earliest next grant visible in cycle m+2.
- Back-to-back different owners: exactly 1 dead cycle between grant pulses.
- Maximum ownership is `MAX_HOLD` cycles of grant.
  - Timed-out owner: grant high for cycles 1..`MAX_HOLD`.
  - TURN with `timeout=1` in cycle `MAX_HOLD`+1.
- A requester dropping `req` on the same edge as the timeout is treated as a normal release: no timeout, no block.
- Worst-case wait for an unblocked, continuously requesting processor: 3×(`MAX_HOLD`+1) cycles.
- All outputs are registered or derived from registers only; no combinational path from `req` to `grant`.

## Test plan
- Reset: hold `reset=0` with `req=4'b1111` -> `grant=0`, `busy=0`, `owner=0`, `timeout=0`. Release reset -> `grant=4'b0001` one cycle later.
- Rotation: `req=4'b1111`, each owner drops `req` for 1 cycle after 3 grant cycles -> grant order 0,1,2,3,0. Each ownership is 3 cycles, separated by exactly 1 zero-grant cycle.
- Single requester re-grant: only `req[2]`, dropped for one cycle and then raised -> grant 2, TURN, IDLE, grant 2 again. `ptr` ends at 3.
- Timeout, `MAX_HOLD=4`: `req[1]` held high permanently, `req[3]` high.
  - `grant[1]` for 4 cycles, then TURN with `timeout=1`, then `grant[3]`.
  - `req[1]` is never granted again until it has been sampled low once.
- Simultaneous drop at limit, `MAX_HOLD=4`: `req[0]` falls on the 4th grant cycle edge -> `timeout=0`, `blocked[0]` stays 0.
- Reset mid-ownership: assert `reset=0` during cycle 2 of `grant[2]` -> `grant` falls asynchronously without waiting for `clk`. After release with `req=4'b0110`, next grant is `grant[1]` (`ptr=0`).

Source files
------------

// File: rtl/accumulator_bus_arbiter_if.sv
// Request/grant bundle for the shared accumulator memory bus.
// Handshake: req[i] is a level request. grant[i] is the registered reply.
// A requester owns the bus for every cycle in which grant[i] is high, and keeps it while req[i] stays high.
// busy mirrors |grant. owner names the current grantee, or the last grantee when the bus is idle.
// timeout pulses for one cycle after the arbiter forcibly takes the bus back.
interface accumulator_bus_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         busy;
  logic [1:0]   owner;
  logic         timeout;

  // Requesters drive req and observe the grant side.
  modport master (
    output req,
    input  grant, busy, owner, timeout
  );

  // The arbiter observes req and drives the grant side.
  modport slave (
    input  req,
    output grant, busy, owner, timeout
  );
endinterface

// File: rtl/accumulator_bus_arbiter.sv
// Round-robin arbiter for four processors sharing the accumulator memory bus.
// Ownership is held while req stays high. One dead turnaround cycle follows every release.
// An owner that hits MAX_HOLD is forced off and blocked until it drops req.
module accumulator_bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  accumulator_bus_arbiter_if.slave    bus,
  output logic [1:0]                  dbg_state,
  output logic [1:0]                  dbg_ptr,
  output logic [N-1:0]                dbg_blocked
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] grant_q, grant_d;
  logic [N-1:0] blocked_q, blocked_d;
  logic [1:0]   owner_q, owner_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [7:0]   hold_q, hold_d;
  logic         timeout_q, timeout_d;

  logic [N-1:0] eligible;
  logic         found;
  logic [1:0]   win;
  logic [1:0]   idx;

  // Round-robin pick: the first eligible index at or after ptr, wrapping modulo 4.
  always_comb begin
    eligible = bus.req & ~blocked_q;
    found    = 1'b0;
    win      = 2'd0;
    idx      = 2'd0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next state, grant and bookkeeping. A block bit is cleared on every edge where its req is sampled low.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    blocked_d = blocked_q & bus.req;
    case (state_q)
      ST_IDLE, ST_TURN: begin
        if (found) begin
          state_d      = ST_OWN;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          owner_d      = win;
          hold_d       = 8'd1;
          ptr_d        = win + 2'd1;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      ST_OWN: begin
        if (!bus.req[owner_q]) begin
          state_d = ST_TURN;
          grant_d = '0;
          hold_d  = 8'd0;
        end else if (hold_q == 8'(MAX_HOLD)) begin
          // Forced release: the owner still requests, so it is blocked from winning again.
          state_d            = ST_TURN;
          grant_d            = '0;
          hold_d             = 8'd0;
          timeout_d          = 1'b1;
          blocked_d[owner_q] = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        hold_d  = 8'd0;
      end
    endcase
  end

  // State register. Reset drops the grant immediately, without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      blocked_q <= '0;
      owner_q   <= 2'd0;
      ptr_q     <= 2'd0;
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      blocked_q <= blocked_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = |grant_q;
  assign bus.owner   = owner_q;
  assign bus.timeout = timeout_q;

  assign dbg_state   = state_q;
  assign dbg_ptr     = ptr_q;
  assign dbg_blocked = blocked_q;

endmodule

// File: tb/tb_accumulator_bus_arbiter.sv
// Bench for accumulator_bus_arbiter with MAX_HOLD=4.
// Directed scenarios are followed by randomized request traffic.
// Each cycle is compared against a transaction-level model of the arbitration rules.
module tb_accumulator_bus_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  logic [1:0] dbg_ptr;
  logic [3:0] dbg_blocked;

  accumulator_bus_arbiter_if #(.N(N)) bus ();

  accumulator_bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state   (dbg_state),
    .dbg_ptr     (dbg_ptr),
    .dbg_blocked (dbg_blocked)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [3:0] exp_q[$];

  // Model state: m_grant is the index of the current owner, or -1 when nobody holds the bus.
  int         m_grant;
  int         m_owner;
  int         m_cnt;
  int         m_ptr;
  logic [3:0] m_blocked;
  logic       m_timeout;
  int         timeouts_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_grant   = -1;
    m_owner   = 0;
    m_cnt     = 0;
    m_ptr     = 0;
    m_blocked = 4'b0000;
    m_timeout = 1'b0;
  endtask

  // One clock edge of the arbitration rules, given the sampled request vector.
  task automatic model_step(input logic [3:0] r);
    logic [3:0] nb;
    nb        = m_blocked & r;
    m_timeout = 1'b0;
    if (m_grant >= 0) begin
      if (!r[m_grant]) begin
        m_grant = -1;
      end else if (m_cnt == MAX_HOLD) begin
        nb[m_grant] = 1'b1;
        m_timeout   = 1'b1;
        m_grant     = -1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (m_grant < 0 && r[i] && !m_blocked[i]) begin
          m_grant = i;
          m_owner = i;
          m_cnt   = 1;
          m_ptr   = (i + 1) % 4;
        end
      end
    end
    m_blocked = nb;
  endtask

  function automatic logic [3:0] exp_grant();
    logic [3:0] g;
    g = 4'b0000;
    if (m_grant >= 0) g[m_grant] = 1'b1;
    return g;
  endfunction

  // Scoreboard: pop the expected grant and compare all visible outputs.
  task automatic compare();
    logic [3:0] g;
    g = exp_q.pop_front();
    check("grant",   bus.grant,   g);
    check("busy",    bus.busy,    |g);
    check("owner",   bus.owner,   m_owner);
    check("timeout", bus.timeout, m_timeout);
    check("ptr",     dbg_ptr,     m_ptr);
    check("blocked", dbg_blocked, m_blocked);
    if (bus.timeout === 1'b1) timeouts_seen = timeouts_seen + 1;
  endtask

  // Driver: present req, let one edge happen, then sample 1 ns later.
  task automatic tick(input logic [3:0] r);
    bus.req = r;
    @(posedge clk);
    model_step(r);
    exp_q.push_back(exp_grant());
    #1;
    compare();
  endtask

  // Reset is asserted and released at the falling edge. Outputs are checked while reset is held.
  task automatic do_reset(input logic [3:0] r);
    @(negedge clk);
    bus.req = r;
    reset   = 1'b0;
    m_reset();
    exp_q.delete();
    #2;
    check("rst_grant",   bus.grant,   4'b0000);
    check("rst_busy",    bus.busy,    1'b0);
    check("rst_owner",   bus.owner,   2'd0);
    check("rst_timeout", bus.timeout, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int         exp_order[5];
    int         obs_order[$];
    logic [3:0] prev_g;
    logic [3:0] r;
    int         g1_cycles;

    exp_order     = '{0, 1, 2, 3, 0};
    timeouts_seen = 0;
    reset         = 1'b0;
    bus.req       = 4'b0000;
    m_reset();
    repeat (2) @(posedge clk);

    // Reset with all requests high, then the first grant goes to processor 0.
    do_reset(4'b1111);
    tick(4'b1111);
    check("first_grant", bus.grant, 4'b0001);

    // Rotation: each owner drops req after 3 grant cycles.
    do_reset(4'b1111);
    prev_g = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      r = 4'b1111;
      if (m_grant >= 0 && m_cnt == 3) r[m_grant] = 1'b0;
      tick(r);
      if (bus.grant != 4'b0000 && prev_g == 4'b0000) obs_order.push_back(int'(bus.owner));
      prev_g = bus.grant;
    end
    check("rot_count", obs_order.size(), 5);
    for (int i = 0; i < 5 && i < obs_order.size(); i++)
      check("rot_order", obs_order[i], exp_order[i]);

    // A single requester is granted, released, and then re-granted.
    do_reset(4'b0100);
    tick(4'b0100);
    check("single_grant", bus.grant, 4'b0100);
    tick(4'b0100);
    tick(4'b0000);
    tick(4'b0000);
    tick(4'b0100);
    tick(4'b0100);
    check("single_regrant", bus.grant, 4'b0100);
    check("single_ptr", dbg_ptr, 2'd3);

    // Timeout: processors 1 and 3 request continuously.
    do_reset(4'b1010);
    timeouts_seen = 0;
    g1_cycles     = 0;
    for (int c = 0; c < 5; c++) begin
      tick(4'b1010);
      if (bus.grant === 4'b0010) g1_cycles = g1_cycles + 1;
    end
    check("to_hold_len", g1_cycles, MAX_HOLD);
    tick(4'b1010);
    check("to_next_owner", bus.grant, 4'b1000);
    for (int c = 0; c < 8; c++) begin
      tick(4'b1010);
      check("to_no_regrant1", bus.grant[1], 1'b0);
    end
    check("to_pulses", timeouts_seen, 2);
    tick(4'b1000);
    tick(4'b1010);
    tick(4'b1010);
    check("to_regrant1", bus.grant, 4'b0010);

    // Dropping req on the edge where the hold limit is reached is a normal release.
    do_reset(4'b0001);
    for (int c = 0; c < MAX_HOLD; c++) tick(4'b0001);
    tick(4'b0000);
    check("drop_timeout", bus.timeout, 1'b0);
    check("drop_blocked", dbg_blocked[0], 1'b0);
    tick(4'b0001);

    // Reset mid-ownership drops the grant before the next clock edge.
    do_reset(4'b0100);
    tick(4'b0100);
    tick(4'b0100);
    #3;
    reset = 1'b0;
    #1;
    check("async_grant", bus.grant, 4'b0000);
    m_reset();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    tick(4'b0110);
    check("post_rst_grant", bus.grant, 4'b0010);

    // Randomized traffic: each request bit toggles now and then, so some owners hold long enough to time out.
    r = 4'($urandom_range(0, 15));
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      tick(r);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
